// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative 32-bit multiply/divide unit with architectural HI/LO.
// A started operation takes 32 CALC cycles plus one FIX cycle. The result
// lands in HI/LO at the FIX edge, and 'done' pulses in the cycle after it.
// Build option: define MDU_DIV_EN to include div/divu. When it is undefined,
// the divide datapath is absent and ops 10/11 are ignored.
module mdu_hilo (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's-complement negation helpers shared by operand capture and result fix
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    neg64 = ~v + 64'd1;
  endfunction

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [1:0]  op_r;
  logic [31:0] a_abs_r;
  logic        sign_res_r;
  logic [63:0] acc_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic        op_legal_s;
  logic        accept_s;
  logic [31:0] a_abs_s;
  logic [31:0] b_abs_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

`ifdef MDU_DIV_EN
  logic [31:0] b_abs_r;
  logic        sign_a_r;
  logic [31:0] rem_r;
  logic [32:0] div_shift_s;
  logic [33:0] div_diff_s;
  logic [31:0] div_rem_next_s;
  logic [31:0] div_q_next_s;
  logic        unused_div_s;
`endif

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

  // Decide whether a start request in IDLE launches an operation
  always_comb begin
`ifdef MDU_DIV_EN
    op_legal_s = 1'b1;
`else
    op_legal_s = ~op[1];
`endif
    if (start && (state_r == S_IDLE) && op_legal_s) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Operand magnitudes: signed ops (op[0]=0) take |x|, unsigned ops pass raw
  always_comb begin
    if (!op[0] && a[31]) begin
      a_abs_s = neg32(a);
    end else begin
      a_abs_s = a;
    end
    if (!op[0] && b[31]) begin
      b_abs_s = neg32(b);
    end else begin
      b_abs_s = b;
    end
  end

  // One shift-add multiply step: multiplier sits in acc low half, LSB first
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, a_abs_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[63:32]};
    end
    mul_next_s = {mul_sum_s, acc_r[31:1]};
  end

`ifdef MDU_DIV_EN
  // One restoring divide step: dividend bits shift in MSB first from acc low
  always_comb begin
    div_shift_s = {rem_r, acc_r[31]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_abs_r};
    if (!div_diff_s[33]) begin
      div_rem_next_s = div_diff_s[31:0];
      div_q_next_s   = {acc_r[30:0], 1'b1};
    end else begin
      div_rem_next_s = div_shift_s[31:0];
      div_q_next_s   = {acc_r[30:0], 1'b0};
    end
  end

  // A successful subtract always leaves a remainder below the divisor, so bit 32 is zero
  assign unused_div_s = div_diff_s[32];
`endif

  // Final sign correction and special cases that form the HI/LO write data
  always_comb begin
    fix_hi_s = acc_r[63:32];
    fix_lo_s = acc_r[31:0];
    case (op_r)
      2'b00: begin
        if (sign_res_r) begin
          {fix_hi_s, fix_lo_s} = neg64(acc_r);
        end else begin
          {fix_hi_s, fix_lo_s} = acc_r;
        end
      end
      2'b01: begin
        {fix_hi_s, fix_lo_s} = acc_r;
      end
`ifdef MDU_DIV_EN
      2'b10: begin
        if (b_abs_r == 32'd0) begin
          // Undo the magnitude capture so HI returns the original dividend
          if (sign_a_r) begin
            fix_hi_s = neg32(a_abs_r);
          end else begin
            fix_hi_s = a_abs_r;
          end
          fix_lo_s = 32'hFFFF_FFFF;
        end else begin
          if (sign_a_r) begin
            fix_hi_s = neg32(rem_r);
          end else begin
            fix_hi_s = rem_r;
          end
          if (sign_res_r) begin
            fix_lo_s = neg32(acc_r[31:0]);
          end else begin
            fix_lo_s = acc_r[31:0];
          end
        end
      end
      2'b11: begin
        if (b_abs_r == 32'd0) begin
          fix_hi_s = a_abs_r;
          fix_lo_s = 32'hFFFF_FFFF;
        end else begin
          fix_hi_s = rem_r;
          fix_lo_s = acc_r[31:0];
        end
      end
`endif
      default: begin
        {fix_hi_s, fix_lo_s} = acc_r;
      end
    endcase
  end

  // Control FSM, iteration datapath and HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_r    <= S_IDLE;
      cnt_r      <= 5'd0;
      op_r       <= 2'd0;
      a_abs_r    <= 32'd0;
      sign_res_r <= 1'b0;
      acc_r      <= 64'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef MDU_DIV_EN
      b_abs_r    <= 32'd0;
      sign_a_r   <= 1'b0;
      rem_r      <= 32'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r    <= S_CALC;
            busy_r     <= 1'b1;
            cnt_r      <= 5'd0;
            op_r       <= op;
            a_abs_r    <= a_abs_s;
            sign_res_r <= a[31] ^ b[31];
`ifdef MDU_DIV_EN
            b_abs_r    <= b_abs_s;
            sign_a_r   <= a[31];
            rem_r      <= 32'd0;
            if (op[1]) begin
              acc_r <= {32'd0, a_abs_s};
            end else begin
              acc_r <= {32'd0, b_abs_s};
            end
`else
            acc_r      <= {32'd0, b_abs_s};
`endif
          end else if (!start) begin
            if (mthi) begin
              hi_r <= a;
            end else begin
              hi_r <= hi_r;
            end
            if (mtlo) begin
              lo_r <= a;
            end else begin
              lo_r <= lo_r;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt_r <= cnt_r + 5'd1;
`ifdef MDU_DIV_EN
          if (op_r[1]) begin
            acc_r <= {32'd0, div_q_next_s};
            rem_r <= div_rem_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
`else
          acc_r <= mul_next_s;
`endif
          if (cnt_r == 5'd31) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo. An arithmetic reference model (plain * / %)
// with a latency counter is compared to the DUT on every falling edge. Directed
// cases pin known literal results. A randomized run follows.
module tb_mdu_hilo;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mdu_hilo dut (
    .clk  (clk),
    .clrn (clrn),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .mthi (mthi),
    .mtlo (mtlo),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", nm, $time, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions; returns {hi, lo}
  function automatic logic [63:0] model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int xi, yi;
    logic [63:0] r;
    r = 64'd0;
    case (o)
      2'b00: begin
        sx = $signed(x);
        sy = $signed(y);
        r = sx * sy;
      end
      2'b01: r = {32'd0, x} * {32'd0, y};
      2'b10: begin
        xi = x;
        yi = y;
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(xi % yi), 32'(xi / yi)};
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  function automatic bit op_legal(input logic [1:0] o);
`ifdef MDU_DIV_EN
    return 1'b1;
`else
    return ~o[1];
`endif
  endfunction

  // Behavioural model: pending result released 33 edges after the accepting edge
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          m_cnt;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    armed = 1'b1;
    if (!clrn) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else if (m_busy) begin
      m_done = 1'b0;
      m_cnt++;
      if (m_cnt == 33) begin
        m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start && op_legal(op)) begin
        {p_hi, p_lo} = model_op(op, a, b);
        m_busy = 1'b1;
        m_cnt = 0;
      end else if (!start) begin
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
    end
  end

  // Launch one op from a falling edge and wait (bounded) for its done cycle
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int mt_at, input bit mt_now);
    int cyc;
    bit got;
    start = 1'b1; op = o; a = x; b = y; mtlo = mt_now;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      mtlo = (i == mt_at);
      if (i == mt_at) a = 32'hDEAD_BEEF;
      if (done) got = 1'b1;
      else if (busy) cyc++;
    end
    mtlo = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    check("busy_cycles", 32'(cyc), 32'd33);
  endtask

  logic [31:0] ra, rb;

  initial begin
    clrn = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    do_op(2'b00, 32'd7, 32'd6, -1, 1'b0);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd42);

    mthi = 1'b1; a = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, 32'd42);

`ifdef MDU_DIV_EN
    do_op(2'b11, 32'd100, 32'd7, -1, 1'b0);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'h0000_1234, 32'd0, -1, 1'b0);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h0000_1234);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("divov_lo", lo, 32'h8000_0000);
    check("divov_hi", hi, 32'd0);
`else
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("nodiv_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    check("nodiv_hi", hi, 32'hA5A5_A5A5);
    check("nodiv_lo", lo, 32'd42);
`endif

    do_op(2'b01, 32'd3, 32'd4, 5, 1'b0);
    check("mtlo_busy_lo", lo, 32'd12);
    check("mtlo_busy_hi", hi, 32'd0);
    do_op(2'b01, 32'd5, 32'd5, -1, 1'b1);
    check("start_mtlo_lo", lo, 32'd25);

    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    clrn = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    clrn = 1'b1;
    repeat (40) @(negedge clk);

    // Randomized traffic: starts, moves, starts during busy, rare resets
    for (int n = 0; n < 3000; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'hFFFF_FFFF;
        3: ra = $urandom_range(0, 300);
        default: ;
      endcase
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom);
      a     = ra;
      b     = rb;
      mthi  = ($urandom_range(0, 6) == 0);
      mtlo  = ($urandom_range(0, 6) == 0);
      clrn  = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; clrn = 1'b1;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file: operands come from the two read ports (a from qa, b from qb), and results land in HI/LO for later mfhi/mflo reads. Operations take multiple cycles, so `busy` is exported to stall the PC and writeback in the control unit.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `clrn` in 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `start` in 1: launch the operation in `op` using `a`/`b`.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` in 32: rs operand (multiplicand/dividend); also the mthi/mtlo data.
- `b` in 32: rt operand (multiplier/divisor).
- `mthi` in 1: write `a` to HI.
- `mtlo` in 1: write `a` to LO.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: operation in flight; new `start`/`mthi`/`mtlo` are ignored.
- `done` out 1: one-cycle pulse; HI/LO hold a fresh result.

## Operation
- Reset (`clrn`=0 at an edge): state goes to IDLE; `hi`, `lo`, `busy`, `done` = 0; the iteration counter and internal accumulators are cleared. Reset mid-operation aborts the operation; no result is written.
- States:
  - IDLE -> CALC on `start`, with that op legal.
  - CALC runs 32 iterations, then -> FIX.
  - FIX -> IDLE unconditionally.
- Start capture (IDLE, `start`=1) latches the following:
  - `op`.
  - `|a|` and `|b|` (absolute value for signed ops; raw for unsigned ops).
  - The sign of `a`, and the result sign, sign(a) xor sign(b).
  - Counter = 0.
- Multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring division, one quotient bit per cycle, MSB first. The 33-bit partial remainder is compared/subtracted against the zero-extended divisor.
- FIX writes `hi`/`lo`:
  - Signed multiply: the 64-bit product is two's-complement negated if the result sign is 1.
  - Signed divide: the quotient is negated if the result sign is 1; the remainder is negated if sign(a) is 1.
  - HI = upper product / remainder.
  - LO = lower product / quotient.
- Divide by zero (b = 0, div or divu): LO = 0xFFFFFFFF, HI = `a` unmodified, with no sign fix. Latency is the same as a normal divide.
- Signed overflow (0x80000000 div 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- mthi/mtlo (IDLE, `start`=0): the selected register(s) load `a` at the edge. Both asserted writes both.
- Simultaneous `start` with mthi/mtlo in IDLE: `start` wins; the move is ignored.
- Any `start`/`mthi`/`mtlo` while `busy`=1: ignored, with no queueing.
- `hi`/`lo` hold their previous values for the whole operation until FIX; there are no partial updates.

## Timing
- `start` sampled at edge k:
  - `busy` = 1 from after edge k through the cycle before edge k+33.
  - HI/LO are written at edge k+33.
  - `done` = 1 for the single cycle after edge k+33.
  - `busy` = 0 in that same cycle.
- A back-to-back `start` is accepted in the `done` cycle (the FSM is already in IDLE), giving a throughput of one operation per 34 cycles.
- mthi/mtlo latency: 1 edge. `done` is not asserted.
- `busy` and `done` are registered outputs, with no combinational path from the inputs.
- `hi`/`lo` are driven directly from registers.

## Configuration
- Macro: `MDU_DIV_EN`.
- Defined:
  - op 10/11 perform div/divu as specified above.
  - The divide datapath (33-bit subtractor, divide-by-zero handling) is present.
- Undefined:
  - The divide datapath is omitted.
  - `start` with op 10/11 is ignored: the FSM stays IDLE, `busy`/`done` stay 0, and HI/LO are unchanged.
  - mult/multu and mthi/mtlo are unaffected.

## Test plan
- Reset checks:
  - `clrn`=0 for 2 edges -> `hi`=`lo`=0, `busy`=`done`=0.
  - Start multu, then drop `clrn` at edge k+10 -> at the next edge `busy`=0, `hi`=`lo`=0, and `done` never pulses.
- multu with a=b=0xFFFFFFFF at edge k -> `busy` for 33 cycles, `done` after edge k+33, HI=0xFFFFFFFE, LO=0x00000001.
- mult with a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Re-assert `start` in the `done` cycle with a=7, b=6 -> accepted, HI=0, LO=42.
- divu 100/7 -> LO=14, HI=2.
- div with a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero (`MDU_DIV_EN` on): divu with a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234.
- Divide compiled out (`MDU_DIV_EN` off): div start -> `busy` stays 0, HI/LO unchanged.
- Moves:
  - mthi with a=0xA5A5A5A5 in IDLE -> HI=0xA5A5A5A5 after 1 edge, LO unchanged.
  - mtlo asserted during `busy` -> LO unchanged.
  - `start` together with mtlo in IDLE -> the operation runs and the mtlo is dropped.
